// File: rtl/spmv_sched_pkg.sv
// spmv_sched_pkg: shared scheduler state encoding and read-latency legality helper
package spmv_sched_pkg;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} sched_state_t;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;
  function automatic bit rd_lat_legal(int lat);
    return lat >= RD_LAT_MIN && lat <= RD_LAT_MAX;
  endfunction
endpackage

// File: rtl/rr_pick_nonempty.sv
// rr_pick_nonempty: combinational round-robin priority encoder starting at rr_ptr
module rr_pick_nonempty #(
  parameter int W = 4,
  localparam int N = 2**W
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] rr_ptr,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_vld
);
  logic [N-1:0] rot;
  logic [W-1:0] off;
  always_comb begin
    rot = N'({req, req} >> rr_ptr);
    off = '0;
    for (int i = N - 1; i >= 0; i--) if (rot[i]) off = W'(i);
    gnt_idx = rr_ptr + off;
    gnt_vld = |req;
  end
endmodule

// File: rtl/packed_q_rr_sched.sv
// packed_q_rr_sched: push admission, round-robin pop issue and result hold for packed queues
module packed_q_rr_sched
  import spmv_sched_pkg::*;
#(
  parameter int BITS_ADDR_PACK   = 4,
  parameter int NUM_OF_Q         = 2**BITS_ADDR_PACK,
  parameter int BITS_ADDR_EACH_Q = 2,
  parameter int DEPTH_EACH_Q     = 2**BITS_ADDR_EACH_Q,
  parameter int RD_LAT           = 1
) (
  input  logic                                     clk,
  input  logic                                     rst_b,
  input  logic                                     sched_en,
  input  logic                                     wr_req,
  input  logic [BITS_ADDR_PACK-1:0]                wr_q,
  output logic                                     wr_grant,
  output logic                                     wr_ptr_inc,
  output logic [BITS_ADDR_PACK-1:0]                wr_addr,
  output logic                                     rd_ptr_inc,
  output logic [BITS_ADDR_PACK-1:0]                rd_addr,
  input  logic [BITS_ADDR_EACH_Q-1:0]              rd_ptr_val,
  output logic [BITS_ADDR_PACK+BITS_ADDR_EACH_Q-1:0] stor_rd_addr,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [BITS_ADDR_PACK-1:0]                out_q,
  output logic [NUM_OF_Q-1:0]                      q_nonempty,
  output logic                                     busy
);
  localparam int CW = BITS_ADDR_EACH_Q + 1;

  if (!rd_lat_legal(RD_LAT) || BITS_ADDR_EACH_Q < 1) begin : g_bad_cfg
    $error("packed_q_rr_sched: RD_LAT must be 1..3 and BITS_ADDR_EACH_Q >= 1");
  end

  sched_state_t state, state_nxt;
  logic [1:0] lat_cnt, lat_nxt;
  logic [BITS_ADDR_PACK-1:0] rr_ptr, grant;
  logic gnt_vld, issue;
  logic [CW-1:0] cnt [NUM_OF_Q];

  rr_pick_nonempty #(.W(BITS_ADDR_PACK)) u_pick (
    .req     (q_nonempty),
    .rr_ptr  (rr_ptr),
    .gnt_idx (grant),
    .gnt_vld (gnt_vld)
  );

  assign issue = sched_en & gnt_vld & (state == S_IDLE | (state == S_HOLD & out_ready));
  // A same-queue pop wins: the pointer block cannot advance both pointers of one queue at once
  assign wr_grant   = wr_req & (cnt[wr_q] != CW'(DEPTH_EACH_Q)) & ~(issue & (wr_q == grant));
  assign wr_ptr_inc = wr_grant;
  assign wr_addr    = wr_q;

  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b)
      for (int i = 0; i < NUM_OF_Q; i++) cnt[i] <= '0;
    else
      for (int i = 0; i < NUM_OF_Q; i++)
        cnt[i] <= cnt[i] + CW'(wr_grant && wr_q == BITS_ADDR_PACK'(i))
                         - CW'(issue && grant == BITS_ADDR_PACK'(i));

  always_comb
    for (int i = 0; i < NUM_OF_Q; i++) q_nonempty[i] = |cnt[i];

  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      state        <= S_IDLE;
      lat_cnt      <= '0;
      rr_ptr       <= '0;
      stor_rd_addr <= '0;
      out_q        <= '0;
    end else begin
      state   <= state_nxt;
      lat_cnt <= lat_nxt;
      if (issue) begin
        rr_ptr       <= grant + BITS_ADDR_PACK'(1);
        stor_rd_addr <= {grant, rd_ptr_val};
        out_q        <= grant;
      end
    end

  always_comb begin
    state_nxt = issue                                  ? S_WAIT :
                state == S_WAIT                        ? (lat_cnt == '0 ? S_HOLD : S_WAIT) :
                (state == S_HOLD && out_ready)         ? S_IDLE : state;
    lat_nxt   = issue                                  ? 2'(RD_LAT - 1) :
                (state == S_WAIT && lat_cnt != '0)     ? lat_cnt - 2'd1 : lat_cnt;
  end

  always_comb begin
    rd_ptr_inc = issue;
    rd_addr    = grant;
    out_valid  = state == S_HOLD;
    busy       = state != S_IDLE;
  end
endmodule
